// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the branch predictor.
//   bp_state_e     - 2-bit saturating predictor state encoding
//   BP_RESET_STATE - state every table entry takes on reset (WEAK_NT)
//   bp_step()      - one saturating step of a predictor state
package bp_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_state_e;

    localparam bp_state_e BP_RESET_STATE = WEAK_NT;

    // Taken moves toward STRONG_T, not-taken toward STRONG_NT; both ends saturate.
    function automatic bp_state_e bp_step(input bp_state_e s, input logic taken);
        bp_state_e r;
        r = s;
        case (s)
            STRONG_NT: r = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   r = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    r = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  r = taken ? STRONG_T : WEAK_T;
            default:   r = BP_RESET_STATE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bp_counter2.sv
// bp_counter2: one 2-bit saturating branch predictor state machine.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset, forces BP_RESET_STATE
//   upd_en    - step the state on this edge
//   upd_taken - direction of the step (1 = taken)
//   state     - current registered state
module bp_counter2
    import bp_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      upd_en,
    input  logic      upd_taken,
    output bp_state_e state
);

    bp_state_e state_q;
    bp_state_e state_d;

    always_comb begin
        state_d = state_q;
        if (upd_en) begin
            state_d = bp_step(state_q, upd_taken);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BP_RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side 2-bit branch predictor and EX-stage resolution.
// A direct-mapped, untagged table of 2**IDX_WIDTH saturating counters is
// indexed by pc[IDX_WIDTH+1:2].
// Ports:
//   clk, reset (async, active-low)
//   fetch_pc / fetch_is_branch / fetch_target  - IF lookup inputs
//   pred_taken / next_pc / save_pc             - prediction for IF/ID
//   res_valid / res_pc / res_taken / res_prediction / res_save_pc - EX resolution
//   flush / redirect_valid / redirect_pc       - mispredict recovery
// Optional macro BP_STATS_EN adds 32-bit saturating outputs stat_branches and
// stat_mispredicts (cleared by reset).
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int IDX_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] fetch_pc,
    input  logic                fetch_is_branch,
    input  logic [PC_WIDTH-1:0] fetch_target,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic [PC_WIDTH-1:0] save_pc,
    input  logic                res_valid,
    input  logic [PC_WIDTH-1:0] res_pc,
    input  logic                res_taken,
    input  logic                res_prediction,
    input  logic [PC_WIDTH-1:0] res_save_pc,
    output logic                flush,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int NUM_ENTRIES = 2 ** IDX_WIDTH;

    logic [IDX_WIDTH-1:0] fetch_idx;
    logic [IDX_WIDTH-1:0] res_idx;
    bp_state_e            entry_state [NUM_ENTRIES];
    bp_state_e            fetch_state;
    logic [PC_WIDTH-1:0]  pc_plus4;
    logic                 mispredict;
    logic                 res_pc_unused;

    assign fetch_idx = fetch_pc[IDX_WIDTH+1:2];
    assign res_idx   = res_pc[IDX_WIDTH+1:2];

    // Only the index bits of the resolving PC matter: the table has no tags.
    assign res_pc_unused = ^{res_pc[PC_WIDTH-1:IDX_WIDTH+2], res_pc[1:0]};

    generate
        for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
            logic upd_en;
            assign upd_en = res_valid && (res_idx == IDX_WIDTH'(i));
            bp_counter2 u_ctr (
                .clk       (clk),
                .reset     (reset),
                .upd_en    (upd_en),
                .upd_taken (res_taken),
                .state     (entry_state[i])
            );
        end
    endgenerate

    // Lookup reads the registered table only, so a same-cycle update to the
    // same entry is not seen until the following cycle.
    assign fetch_state = entry_state[fetch_idx];
    assign pc_plus4    = fetch_pc + PC_WIDTH'(4);

    always_comb begin
        pred_taken = 1'b0;
        next_pc    = pc_plus4;
        save_pc    = pc_plus4;
        if (fetch_is_branch) begin
            pred_taken = fetch_state[1];
            if (fetch_state[1]) begin
                next_pc = fetch_target;
                save_pc = pc_plus4;
            end else begin
                next_pc = pc_plus4;
                save_pc = fetch_target;
            end
        end
    end

    always_comb begin
        mispredict     = res_valid && (res_taken != res_prediction);
        flush          = mispredict;
        redirect_valid = mispredict;
        redirect_pc    = '0;
        if (mispredict) begin
            redirect_pc = res_save_pc;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_branches_d;
    logic [31:0] stat_mispredicts_q;
    logic [31:0] stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (res_valid && (stat_branches_q != '1)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (mispredict && (stat_mispredicts_q != '1)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed test-plan sequence plus randomized traffic,
// checked every cycle against a behavioural model of the predictor table.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        fetch_is_branch;
    logic [31:0] fetch_target;
    logic        pred_taken;
    logic [31:0] next_pc;
    logic [31:0] save_pc;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic        res_prediction;
    logic [31:0] res_save_pc;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(.PC_WIDTH(32), .IDX_WIDTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_pc        (fetch_pc),
        .fetch_is_branch (fetch_is_branch),
        .fetch_target    (fetch_target),
        .pred_taken      (pred_taken),
        .next_pc         (next_pc),
        .save_pc         (save_pc),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_taken       (res_taken),
        .res_prediction  (res_prediction),
        .res_save_pc     (res_save_pc),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one integer confidence 0..3 per index; taken predicted at >= 2.
    int model_ctr [16];

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_ctr[i] = 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge reset) model_reset();

    always @(posedge clk) begin
        if (reset === 1'b1 && res_valid === 1'b1) begin
            int k;
            k = midx(res_pc);
            if (res_taken) model_ctr[k] = (model_ctr[k] < 3) ? model_ctr[k] + 1 : 3;
            else           model_ctr[k] = (model_ctr[k] > 0) ? model_ctr[k] - 1 : 0;
        end
    end

    // Every cycle with reset released, all outputs must match the model.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            logic        e_pt;
            logic        e_mis;
            logic [31:0] e_p4;
            logic [31:0] e_next;
            logic [31:0] e_save;
            e_p4  = fetch_pc + 32'd4;
            e_pt  = fetch_is_branch && (model_ctr[midx(fetch_pc)] >= 2);
            e_next = e_pt ? fetch_target : e_p4;
            e_save = !fetch_is_branch ? e_p4 : (e_pt ? e_p4 : fetch_target);
            e_mis = res_valid && (res_taken != res_prediction);
            check("cyc_pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
            check("cyc_next_pc", next_pc, e_next);
            check("cyc_save_pc", save_pc, e_save);
            check("cyc_flush", {31'd0, flush}, {31'd0, e_mis});
            check("cyc_redirect_valid", {31'd0, redirect_valid}, {31'd0, e_mis});
            check("cyc_redirect_pc", redirect_pc, e_mis ? res_save_pc : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic [31:0] pc, input logic br, input logic [31:0] tgt);
        fetch_pc = pc;
        fetch_is_branch = br;
        fetch_target = tgt;
    endtask

    task automatic set_res(input logic v, input logic [31:0] pc, input logic tk,
                           input logic pr, input logic [31:0] sv);
        res_valid = v;
        res_pc = pc;
        res_taken = tk;
        res_prediction = pr;
        res_save_pc = sv;
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        set_fetch(32'h0, 1'b0, 32'h0);
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #12 reset = 1'b1;

        // Reset state lookup
        tick();
        set_fetch(32'h40, 1'b1, 32'h80);
        #1;
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_next_pc", next_pc, 32'h44);
        check("rst_save_pc", save_pc, 32'h80);
        check("rst_flush", {31'd0, flush}, 32'd0);

        // Two taken resolutions with a not-taken prediction
        set_res(1'b1, 32'h40, 1'b1, 1'b0, 32'h80);
        #1;
        check("mis1_flush", {31'd0, flush}, 32'd1);
        check("mis1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("mis1_redirect_pc", redirect_pc, 32'h80);
        check("mis1_pred_pre_update", {31'd0, pred_taken}, 32'd0);
        tick();
        #1;
        check("mis2_flush", {31'd0, flush}, 32'd1);
        check("mis2_redirect_pc", redirect_pc, 32'h80);
        check("weak_t_pred", {31'd0, pred_taken}, 32'd1);
        tick();
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h1234);
        #1;
        check("strong_t_pred", {31'd0, pred_taken}, 32'd1);
        check("strong_t_next_pc", next_pc, 32'h80);
        check("strong_t_save_pc", save_pc, 32'h44);
        check("idle_flush", {31'd0, flush}, 32'd0);
        check("idle_redirect_pc", redirect_pc, 32'd0);

        // Not-taken from STRONG_T with a taken prediction
        set_res(1'b1, 32'h40, 1'b0, 1'b1, 32'h44);
        #1;
        check("nt_flush", {31'd0, flush}, 32'd1);
        check("nt_redirect_pc", redirect_pc, 32'h44);
        tick();
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("weak_t_after_nt", {31'd0, pred_taken}, 32'd1);
        set_res(1'b1, 32'h40, 1'b0, 1'b1, 32'h44);
        tick();
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("weak_nt_after_2nt", {31'd0, pred_taken}, 32'd0);

        // Saturation at both ends; correct predictions raise no flush
        set_res(1'b1, 32'h40, 1'b1, 1'b1, 32'h44);
        #1;
        check("correct_no_flush", {31'd0, flush}, 32'd0);
        check("correct_redirect_pc", redirect_pc, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        set_res(1'b1, 32'h40, 1'b0, 1'b0, 32'h44);
        tick();
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("sat_high_then_nt", {31'd0, pred_taken}, 32'd1);
        set_res(1'b1, 32'h40, 1'b0, 1'b0, 32'h44);
        for (int i = 0; i < 5; i++) tick();
        set_res(1'b1, 32'h40, 1'b1, 1'b1, 32'h44);
        tick();
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("sat_low_then_t", {31'd0, pred_taken}, 32'd0);

        // Same-cycle lookup and update: no bypass; alias 0x80 shares the entry
        set_fetch(32'h40, 1'b1, 32'h80);
        set_res(1'b1, 32'h40, 1'b1, 1'b0, 32'h80);
        #1;
        check("same_cycle_pred", {31'd0, pred_taken}, 32'd0);
        tick();
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("next_cycle_pred", {31'd0, pred_taken}, 32'd1);
        set_fetch(32'h80, 1'b1, 32'h100);
        #1;
        check("alias_pred", {31'd0, pred_taken}, 32'd1);
        check("alias_next_pc", next_pc, 32'h100);
        check("alias_save_pc", save_pc, 32'h84);

        // Non-branch fetch and PC wrap-around
        set_fetch(32'h80, 1'b0, 32'h100);
        #1;
        check("nonbr_pred", {31'd0, pred_taken}, 32'd0);
        check("nonbr_next_pc", next_pc, 32'h84);
        check("nonbr_save_pc", save_pc, 32'h84);
        set_fetch(32'hFFFF_FFFC, 1'b0, 32'h0);
        #1;
        check("wrap_next_pc", next_pc, 32'h0);

        // Asynchronous reset between edges clears the trained entry at once
        set_fetch(32'h80, 1'b1, 32'h100);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pred", {31'd0, pred_taken}, 32'd0);
        check("async_rst_next_pc", next_pc, 32'h84);
        #3;
        reset = 1'b1;
        #1;
        check("post_rst_pred", {31'd0, pred_taken}, 32'd0);

`ifdef BP_STATS_EN
        check("stat_br_rst", stat_branches, 32'd0);
        check("stat_mis_rst", stat_mispredicts, 32'd0);
        tick();
        set_res(1'b1, 32'h10, 1'b1, 1'b1, 32'h0);
        tick();
        set_res(1'b1, 32'h14, 1'b0, 1'b1, 32'h18);
        tick();
        set_res(1'b1, 32'h18, 1'b0, 1'b0, 32'h0);
        tick();
        set_res(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("stat_br_3", stat_branches, 32'd3);
        check("stat_mis_1", stat_mispredicts, 32'd1);
`endif

        // Randomized traffic checked by the per-cycle compare process
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 3) == 0) fetch_pc = $urandom;
            else fetch_pc = 32'($urandom_range(0, 63)) << 2;
            fetch_is_branch = 1'($urandom_range(0, 1));
            fetch_target = $urandom;
            res_valid = ($urandom_range(0, 3) != 0);
            res_pc = 32'($urandom_range(0, 31)) << 2;
            res_taken = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 0) res_prediction = (model_ctr[midx(res_pc)] >= 2);
            else res_prediction = 1'($urandom_range(0, 1));
            res_save_pc = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                #4 reset = 1'b1;
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
